// File: rtl/bus_protocol_initiator_pkg.sv
// Shared types for the bus_protocol_if initiator: FSM states, latched command and captured response.
package bus_protocol_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
  } cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        timeout;
  } rsp_t;

endpackage

// File: rtl/bus_protocol_initiator.sv
// Initiator end of the bus_protocol_if request/stall handshake with a stall timeout.
// Command and response ports: a transfer happens on a clock edge where valid && ready are both high.
module bus_protocol_initiator
  import bus_protocol_initiator_pkg::*;
#(
  parameter int TimeoutCycles = 1024
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strobe,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        wen,
  output logic        ren,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  strobe,
  input  logic [31:0] rdata,
  input  logic        error,
  input  logic        request_stall,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  state_e           state, state_nxt;
  cmd_t             cmd_q;
  rsp_t             rsp_q;
  logic             wen_q, ren_q;
  logic [CNT_W-1:0] stall_cnt;
  logic             accept, done, abort;

  always_ff @(posedge clk) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  // The abort fires on the stalled cycle that would exceed the budget, so the
  // request stays on the bus for exactly TimeoutCycles cycles.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: if (cmd_valid) begin
        accept    = 1'b1;
        state_nxt = BUS;
      end
      BUS: begin
        if (!request_stall) begin
          done      = 1'b1;
          state_nxt = RESP;
        end else if ((TimeoutCycles != 0) && (stall_cnt == CNT_LAST)) begin
          abort     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      cmd_q     <= '0;
      rsp_q     <= '0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (accept) begin
        cmd_q <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strobe: cmd_strobe};
        rsp_q <= '0;
        wen_q <= cmd_write;
        ren_q <= !cmd_write;
      end
      if (done) begin
        rsp_q <= '{rdata: (cmd_q.write ? 32'd0 : rdata), error: error, timeout: 1'b0};
        wen_q <= 1'b0;
        ren_q <= 1'b0;
      end
      if (abort) begin
        rsp_q <= '{rdata: 32'd0, error: 1'b1, timeout: 1'b1};
        wen_q <= 1'b0;
        ren_q <= 1'b0;
      end
      if ((state == BUS) && request_stall && !abort) stall_cnt <= stall_cnt + 1'b1;
      if ((state == RESP) && rsp_ready) stall_cnt <= '0;
    end
  end

  assign wen         = wen_q;
  assign ren         = ren_q;
  assign addr        = cmd_q.addr;
  assign wdata       = cmd_q.wdata;
  assign strobe      = cmd_q.strobe;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_error   = rsp_q.error;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_bus_protocol_initiator.sv
// Directed plus randomized bench for bus_protocol_initiator with a transaction-level reference model.
module tb_bus_protocol_initiator;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        nReset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strobe;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error, rsp_timeout;
  logic        wen, ren;
  logic [31:0] addr, wdata;
  logic [3:0]  strobe;
  logic [31:0] rdata;
  logic        error, request_stall;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  bus_protocol_initiator #(.TimeoutCycles(T)) dut (
    .clk(clk), .nReset(nReset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strobe(cmd_strobe),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .wen(wen), .ren(ren), .addr(addr), .wdata(wdata), .strobe(strobe),
    .rdata(rdata), .error(error), .request_stall(request_stall),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver + reference model for one complete transaction.
  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input int stalls, input logic [31:0] rd,
                         input logic er, input int hold);
    bit          to;
    int          vis_exp, lat_exp, vis, k;
    logic [33:0] exp;
    to      = (T != 0) && (stalls >= T);
    vis_exp = to ? T : stalls + 1;
    lat_exp = vis_exp + 1;
    exp_q.push_back({to, (to ? 1'b1 : er), ((to || wr) ? 32'd0 : rd)});

    @(negedge clk);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_strobe = st;
    rdata = rd; error = er; request_stall = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~wr;
    vis = 0;
    k   = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (rsp_valid) break;
      if (wen | ren) begin
        vis++;
        check("bus_addr", addr, a);
        check("bus_wdata", wdata, wd);
        check("bus_strobe", {28'd0, strobe}, {28'd0, st});
        check("bus_wen", {31'd0, wen}, {31'd0, wr});
        check("bus_ren", {31'd0, ren}, {31'd0, ~wr});
        request_stall = (vis <= stalls);
      end
    end
    request_stall = 1'b0;
    check("rsp_latency", k, lat_exp);
    check("bus_visible", vis, vis_exp);

    exp = exp_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      check("rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
      check("rsp_rdata", rsp_rdata, exp[31:0]);
      check("rsp_error", {31'd0, rsp_error}, {31'd0, exp[32]});
      check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, exp[33]});
      check("resp_no_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("resp_no_request", {31'd0, wen | ren}, 32'd0);
      if (i < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    nReset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strobe = '0; rsp_ready = 1'b0; rdata = '0; error = 1'b0; request_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
    @(negedge clk);
    check("reset_wen", {31'd0, wen}, 32'd0);
    check("reset_ren", {31'd0, ren}, 32'd0);
    check("reset_addr", addr, 32'd0);
    check("reset_wdata", wdata, 32'd0);
    check("reset_strobe", {28'd0, strobe}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_flags", {30'd0, rsp_error, rsp_timeout}, 32'd0);
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_dbg_state", {30'd0, dbg_state}, 32'd0);

    run_txn(1'b1, 32'h04, 32'hA5, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0);
    run_txn(1'b0, 32'h00, 32'h0, 4'hF, 5, 32'h0000_0041, 1'b0, 0);
    run_txn(1'b1, 32'h10, 32'h1234, 4'h3, 0, 32'h0, 1'b1, 0);
    run_txn(1'b0, 32'h20, 32'h0, 4'hF, 1000, 32'h5555_AAAA, 1'b0, 1);
    run_txn(1'b0, 32'h24, 32'h0, 4'hF, 0, 32'h0000_0077, 1'b0, 0);
    run_txn(1'b0, 32'h28, 32'h0, 4'hF, T - 1, 32'hCAFE_0001, 1'b0, 10);

    // reset while stalled in BUS
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; request_stall = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    nReset = 1'b0;
    @(posedge clk);
    #1;
    nReset = 1'b1;
    @(negedge clk);
    check("midrst_wen", {31'd0, wen}, 32'd0);
    check("midrst_ren", {31'd0, ren}, 32'd0);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", {31'd0, rsp_valid | wen | ren}, 32'd0);
    end
    request_stall = 1'b0;

    for (int n = 0; n < 25; n++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 10), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
